// File: rtl/data_sram_resp_if.sv
// Request/response bundle between the MEM-stage requestor and the data SRAM.
// The requestor holds en/wen/addr/wdata stable while stallreq is high.
interface data_sram_resp_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        resp_valid;
    logic        addr_err;
    logic        stallreq;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata, resp_valid, addr_err, stallreq
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata, resp_valid, addr_err, stallreq
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM with configurable wait states, byte-lane writes and
// range/alignment checking; one-cycle response pulse per access.
module data_sram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input logic            clk,
    input logic            rst,
    data_sram_resp_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] N = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [3:0]  r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_mem [2**ADDR_W];

    logic              w_accept;
    logic              w_held;
    logic [31:0]       w_addr;
    logic [3:0]        w_wen;
    logic [31:0]       w_wdata;
    logic              w_rd;
    logic              w_err;
    logic              w_go;
    logic [ADDR_W-1:0] w_idx;

    assign w_accept = bus.sram_en && (r_state != S_WAIT);
    assign w_held   = (r_state == S_WAIT);

    // With zero wait states the access uses the live inputs at acceptance.
    assign w_addr  = w_held ? r_addr  : bus.sram_addr;
    assign w_wen   = w_held ? r_wen   : bus.sram_wen;
    assign w_wdata = w_held ? r_wdata : bus.sram_wdata;

    assign w_rd  = (w_wen == 4'b0000);
    assign w_err = (|w_addr[31:ADDR_W+2])
                 || ((w_rd || w_wen == 4'b1111) && (|w_addr[1:0]));
    assign w_go  = (w_accept && N == 4'd0)
                 || (w_held && r_cnt == 4'd1);
    assign w_idx = w_addr[ADDR_W+1:2];

    assign bus.stallreq   = !rst && ((w_accept && N != 4'd0) || w_held);
    assign bus.sram_rdata = r_rdata;
    assign bus.resp_valid = r_valid;
    assign bus.addr_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst && w_go && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wen[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wen   <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_go) begin
                r_valid <= 1'b1;
                r_err   <= w_err;
                if (w_err)     r_rdata <= 32'd0;
                else if (w_rd) r_rdata <= r_mem[w_idx];
            end
            unique case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_addr  <= bus.sram_addr;
                        r_wen   <= bus.sram_wen;
                        r_wdata <= bus.sram_wdata;
                        if (N == 4'd0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= N;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter: ADDR_W, 10, word-address bits; array depth 2^ADDR_W 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, 0, wait states inserted before each access completes (0..15).
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sram_en  input  1  access request from MEM-side requestor.
REQ-007 sram_wen  input  4  byte-lane write enables; 4'b0000 with sram_en = read.
REQ-008 sram_addr  input  32  byte address.
REQ-009 sram_wdata  input  32  write data, lane i = bits [8i+7:8i].
REQ-010 sram_rdata  output  32  registered read data.
REQ-011 resp_valid  output  1  one-cycle pulse: access completed this cycle.
REQ-012 addr_err  output  1  one-cycle pulse with resp_valid: completed access was out of range or misaligned.
REQ-013 stallreq  output  1  pipeline stall request; requestor holds en/wen/addr/wdata stable while high.

Function
REQ-014 FSM states IDLE, WAIT, RESP; request accepted when sram_en=1 in IDLE or RESP.
REQ-015 On acceptance: addr, wen, wdata captured into request register; later input changes ignored until completion.
REQ-016 WAIT_CYCLES=0: access performed at acceptance edge; next state RESP; resp_valid=1 the following cycle.
REQ-017 WAIT_CYCLES=N>0: acceptance edge loads counter with N, next state WAIT; each WAIT edge decrements; access performed at edge where counter=1, next state RESP.
REQ-018 Latency: resp_valid asserted exactly N+1 cycles after acceptance cycle.
REQ-019 stallreq = (acceptance cycle AND N>0) OR state==WAIT, combinational; low in RESP and idle IDLE.
REQ-020 RESP lasts one cycle; new request in RESP accepted (back-to-back); no request -> IDLE.
REQ-021 Write: lane i of word sram_addr[ADDR_W+1:2] updated iff wen[i]=1; other lanes unchanged.
REQ-022 Read: sram_rdata loaded with addressed word at access edge; valid in RESP cycle.
REQ-023 sram_rdata holds last read value through writes, idle and wait cycles.
REQ-024 Out of range: sram_addr[31:ADDR_W+2] != 0 -> no array access, sram_rdata loaded with 0, addr_err=1 in RESP.
REQ-025 Misaligned: wen in {4'b1111} or read with sram_addr[1:0]!=0 -> treated as error, same as REQ-024; byte/halfword wen patterns accept any addr[1:0].
REQ-026 Counter width 4 bits; no wrap: counter never decremented below 1 in WAIT.
REQ-027 sram_en ignored while in WAIT (held request, not a new one).

Reset
REQ-028 rst=1 at edge: state IDLE, counter 0, request register cleared, sram_rdata=0, resp_valid=0, addr_err=0.
REQ-029 stallreq=0 while rst=1 regardless of sram_en.
REQ-030 Reset mid-WAIT: pending access aborted; a pending write does not modify the array.
REQ-031 Array contents not reset; undefined until written.

Verification
REQ-032 N=0: write addr 0x10 wen 1111 data 0xDEADBEEF, then read 0x10 -> resp_valid each next cycle, read returns 0xDEADBEEF, stallreq never high.
REQ-033 N=0: after REQ-032, write 0x10 wen 0010 data 0x0000AA00, read 0x10 -> 0xDEADAAEF.
REQ-034 N=3: read 0x10 -> stallreq high 4 cycles (acceptance + 3 WAIT), resp_valid on 5th cycle, data 0xDEADAAEF; input address changed during stall has no effect.
REQ-035 N=0: read 0x00001000 (ADDR_W=10) -> addr_err=1 with resp_valid, sram_rdata=0; read 0x12 -> addr_err=1.
REQ-036 N=3: write 0x20 data 0x12345678, assert rst in 2nd WAIT cycle; after reset read 0x20 -> value unchanged from prior contents, state IDLE, outputs 0 during reset.
REQ-037 N=2: back-to-back reads 0x10, 0x20 with en held -> second accepted in RESP of first, two resp_valid pulses 3 cycles apart.
